prog_loader: RTL and testbench
==============================

# prog_loader

Byte-stream program loader that sits directly upstream of the simulation top. It accepts a framed byte stream (sync, length, little-endian instruction words, XOR checksum) over a valid/ready handshake. It drives the instruction-memory programming port (`inst`, `inst_mem_offset`, `programming_data_valid`, `programming_done`). It releases the core from reset only after a frame arrives complete and error-free.

## Interface
Parameters:
- `INST_MEM_ADDR_SIZE`, default 10: word-address width of instruction memory; max frame length is 2^INST_MEM_ADDR_SIZE words.
- `TIMEOUT_CYCLES`, default 1_000_000: maximum idle cycles between accepted bytes inside a frame.
- `SYNC_BYTE`, default 8'hA5: frame start marker.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_data`  in  8  stream byte.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  loader can accept a byte; a byte transfers on a rising edge with `in_valid && in_ready`.
- `inst`  out  32  assembled instruction word.
- `inst_mem_offset`  out  INST_MEM_ADDR_SIZE  word index of `inst`.
- `programming_data_valid`  out  1  one-cycle write strobe for `inst`/`inst_mem_offset`.
- `programming_done`  out  1  one-cycle pulse: frame loaded and checksum good.
- `busy`  out  1  high in LEN_LO, LEN_HI, DATA, CSUM.
- `error`  out  1  sticky error flag.
- `err_code`  out  2  00 none, 01 bad length, 10 checksum mismatch, 11 timeout.

## Operation
- Frame format: SYNC_BYTE, LEN_LO, LEN_HI, then LEN×4 data bytes with each word least-significant byte first, then CSUM.
- CSUM is the XOR of LEN_LO, LEN_HI and all data bytes.
- States:
  - IDLE: discard bytes until SYNC_BYTE, then go to LEN_LO.
  - LEN_LO: latch the low length byte, go to LEN_HI.
  - LEN_HI: latch the high byte. A 16-bit LEN of 0 or > 2^INST_MEM_ADDR_SIZE goes to ERR with code 01. Otherwise go to DATA, word index 0, byte lane 0.
  - DATA: shift each byte into lane 0..3. On lane 3, register the word into `inst` with the current index and pulse `programming_data_valid`. Increment the index. After word LEN-1, go to CSUM.
  - CSUM: if the byte equals the running XOR, go to DONE. Otherwise go to ERR with code 10.
  - DONE: pulse `programming_done` for one cycle, then go to IDLE.
  - ERR: `error`=1, `err_code` held. Bytes are accepted and dropped. SYNC_BYTE clears `error`/`err_code` and goes to LEN_LO.
- Timeout: a counter clears on every accepted byte and on every state entry. It counts only in LEN_LO, LEN_HI, DATA and CSUM. On reaching TIMEOUT_CYCLES it goes to ERR with code 11. No further `programming_data_valid` pulses are issued.
- Words already written before an error remain in memory. `programming_done` is never issued for a failed frame, so the core stays held in reset.
- The running XOR and word index are cleared on entry to LEN_LO.
- `inst_mem_offset` is the low INST_MEM_ADDR_SIZE bits of the 16-bit index. The index never exceeds LEN-1.
- A new frame after DONE is accepted normally. Downstream ignores its writes once programming has completed; that filtering is not this block's concern.

## Timing
- Reset (`reset_n` low, asynchronous) sets:
  - state IDLE;
  - `inst`=0, `inst_mem_offset`=0;
  - `programming_data_valid`=0, `programming_done`=0;
  - `busy`=0, `error`=0, `err_code`=00;
  - counters, XOR and lane all 0.
- Reset mid-frame aborts the frame immediately with no strobe.
- `in_ready` is 1 in every state except DONE, so it is 1 from the first cycle after reset release. It is combinational from state and never depends on `in_valid`.
- Latency:
  - The 4th byte of a word is accepted at edge t; `inst`, `inst_mem_offset` and `programming_data_valid`=1 are visible after edge t and held for exactly one cycle.
  - A good CSUM accepted at edge t enters DONE; `programming_done`=1 for the cycle after edge t. The next edge returns to IDLE.
- Back-to-back bytes (in_valid held high) sustain one byte per cycle. Strobes for consecutive words are therefore at least 4 cycles apart.
- A timeout fires at the edge where the counter equals TIMEOUT_CYCLES with no byte accepted. A byte accepted on that same edge wins: the counter clears and no timeout occurs.
- The last data byte and the next state transition share an edge: the strobe for the final word and entry to CSUM occur together.

## Test plan
- Load a 2-word frame (A5 02 00, then bytes for words 0x00000013 and 0x00100093, then CSUM = XOR of 02, 00 and the 8 data bytes) -> valid pulses at offsets 0 and 1 with those words, then one `programming_done` pulse; `error`=0.
- Same frame with CSUM XORed by 0x01 -> both valid pulses occur, no done, `error`=1, `err_code`=10; then A5 clears `error`.
- LEN=0 (A5 00 00) and LEN=1025 (A5 01 04) -> ERR with `err_code`=01 after the LEN_HI byte, zero valid pulses.
- Stall 6 cycles mid-word with TIMEOUT_CYCLES=5 -> ERR, `err_code`=11, no further strobes; a stall of 4 cycles -> frame completes normally.
- Garbage bytes (00 FF 5A) before A5, in_valid toggling randomly -> garbage ignored, same output sequence as the clean stream.
- `reset_n` pulsed low after 5 data bytes -> all outputs 0 immediately; a fresh full frame afterwards loads from offset 0 and produces done.

Source files
------------

// File: rtl/prog_loader_if.sv
// prog_loader_if: groups the byte-stream handshake and the instruction-memory
// programming port of the program loader.
//   in_data/in_valid/in_ready   framed byte stream (upstream -> loader)
//   inst/inst_mem_offset        word and word index being written
//   programming_data_valid      one-cycle write strobe
//   programming_done            one-cycle "frame loaded, checksum good" pulse
//   busy/error/err_code         loader status
// Modports: master = byte source / observer, slave = the loader itself.
interface prog_loader_if #(
  parameter int INST_MEM_ADDR_SIZE = 10
);
  logic [7:0]                    in_data;
  logic                          in_valid;
  logic                          in_ready;
  logic [31:0]                   inst;
  logic [INST_MEM_ADDR_SIZE-1:0] inst_mem_offset;
  logic                          programming_data_valid;
  logic                          programming_done;
  logic                          busy;
  logic                          error;
  logic [1:0]                    err_code;

  modport master (
    output in_data, in_valid,
    input  in_ready, inst, inst_mem_offset, programming_data_valid,
           programming_done, busy, error, err_code
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, inst, inst_mem_offset, programming_data_valid,
           programming_done, busy, error, err_code
  );
endinterface

// File: rtl/prog_loader.sv
// prog_loader: byte-stream program loader. Parses frames of the form
//   SYNC, LEN_LO, LEN_HI, LEN x 4 data bytes (little-endian words), CSUM
// where CSUM is the XOR of the length bytes and all data bytes. Each complete
// word is written to instruction memory with a one-cycle strobe; a frame with
// a good checksum ends with a one-cycle programming_done pulse, which is what
// releases the core from reset downstream.
// Ports:
//   clk      single clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      prog_loader_if.slave (stream in, programming port and status out)
module prog_loader #(
  parameter int         INST_MEM_ADDR_SIZE = 10,
  parameter int         TIMEOUT_CYCLES     = 1_000_000,
  parameter logic [7:0] SYNC_BYTE          = 8'hA5
) (
  input  logic         clk,
  input  logic         reset_n,
  prog_loader_if.slave bus
);

  localparam int          CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [16:0] MAX_LEN = 17'(1) << INST_MEM_ADDR_SIZE;

  typedef enum logic [2:0] {
    IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR
  } state_t;

  state_t             state;
  logic [15:0]        len;
  logic [15:0]        word_idx;
  logic [1:0]         lane;
  logic [23:0]        word_buf;
  logic [7:0]         run_xor;
  logic [CNT_W-1:0]   tmo_cnt;

  logic               accept;
  logic               tmo_hit;
  logic [15:0]        new_len;

  // Ready and busy are pure decodes of the state register.
  assign bus.in_ready = (state != DONE);
  assign bus.busy     = (state == LEN_LO) || (state == LEN_HI) ||
                        (state == DATA)   || (state == CSUM);
  assign accept       = bus.in_valid && bus.in_ready;
  // A byte accepted on the expiry edge wins over the timeout.
  assign tmo_hit      = bus.busy && !accept &&
                        (tmo_cnt == CNT_W'(TIMEOUT_CYCLES));
  assign new_len      = {bus.in_data, len[7:0]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state                      <= IDLE;
      len                        <= '0;
      word_idx                   <= '0;
      lane                       <= '0;
      word_buf                   <= '0;
      run_xor                    <= '0;
      tmo_cnt                    <= '0;
      bus.inst                   <= '0;
      bus.inst_mem_offset        <= '0;
      bus.programming_data_valid <= 1'b0;
      bus.programming_done       <= 1'b0;
      bus.error                  <= 1'b0;
      bus.err_code               <= 2'b00;
    end else begin
      bus.programming_data_valid <= 1'b0;
      bus.programming_done       <= 1'b0;

      // Idle-gap counter; every state entry inside a frame coincides with an
      // accepted byte or a timeout, both of which clear it.
      if (accept || tmo_hit) begin
        tmo_cnt <= '0;
      end else if (bus.busy) begin
        tmo_cnt <= tmo_cnt + CNT_W'(1);
      end

      if (tmo_hit) begin
        state        <= ERR;
        bus.error    <= 1'b1;
        bus.err_code <= 2'b11;
      end else begin
        case (state)
          IDLE: begin
            if (accept && bus.in_data == SYNC_BYTE) begin
              state    <= LEN_LO;
              run_xor  <= '0;
              word_idx <= '0;
              lane     <= '0;
            end
          end

          LEN_LO: begin
            if (accept) begin
              len[7:0] <= bus.in_data;
              run_xor  <= run_xor ^ bus.in_data;
              state    <= LEN_HI;
            end
          end

          LEN_HI: begin
            if (accept) begin
              len     <= new_len;
              run_xor <= run_xor ^ bus.in_data;
              if (new_len == 16'd0 || {1'b0, new_len} > MAX_LEN) begin
                state        <= ERR;
                bus.error    <= 1'b1;
                bus.err_code <= 2'b01;
              end else begin
                state    <= DATA;
                word_idx <= '0;
                lane     <= '0;
              end
            end
          end

          DATA: begin
            if (accept) begin
              run_xor <= run_xor ^ bus.in_data;
              case (lane)
                2'd0: word_buf[7:0]   <= bus.in_data;
                2'd1: word_buf[15:8]  <= bus.in_data;
                2'd2: word_buf[23:16] <= bus.in_data;
                default: begin
                  bus.inst                   <= {bus.in_data, word_buf};
                  bus.inst_mem_offset        <= word_idx[INST_MEM_ADDR_SIZE-1:0];
                  bus.programming_data_valid <= 1'b1;
                  // The index stops at LEN-1; the last word moves on to CSUM.
                  if (word_idx == len - 16'd1) begin
                    state <= CSUM;
                  end else begin
                    word_idx <= word_idx + 16'd1;
                  end
                end
              endcase
              lane <= lane + 2'd1;
            end
          end

          CSUM: begin
            if (accept) begin
              if (bus.in_data == run_xor) begin
                state                <= DONE;
                bus.programming_done <= 1'b1;
              end else begin
                state        <= ERR;
                bus.error    <= 1'b1;
                bus.err_code <= 2'b10;
              end
            end
          end

          DONE: begin
            state <= IDLE;
          end

          ERR: begin
            // Everything but a sync byte is dropped; sync restarts a frame.
            if (accept && bus.in_data == SYNC_BYTE) begin
              state        <= LEN_LO;
              bus.error    <= 1'b0;
              bus.err_code <= 2'b00;
              run_xor      <= '0;
              word_idx     <= '0;
              lane         <= '0;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: self-checking bench for prog_loader. Table-driven frames,
// hand-written latency/timeout/reset sequences and randomized streams are all
// checked against a frame-level reference model that parses the byte list.
module tb_prog_loader;

  localparam int         AW        = 10;
  localparam int         TMO       = 5;
  localparam logic [7:0] SYNC      = 8'hA5;
  localparam int         MAX_WORDS = 1 << AW;

  typedef struct packed {
    logic [AW-1:0] off;
    logic [31:0]   word;
  } wr_t;

  typedef struct {
    string       name;
    logic [15:0] len_field;
    int          nwords;
    bit          fixed;
    logic [7:0]  flip;
    int          exp_writes;
    int          exp_done;
    logic        exp_err;
    logic [1:0]  exp_code;
  } vec_t;

  typedef struct {
    int          stall;
    int          exp_writes;
    int          exp_done;
    logic        exp_err;
    logic [1:0]  exp_code;
  } stall_t;

  logic clk = 1'b0;
  logic reset_n;

  prog_loader_if #(.INST_MEM_ADDR_SIZE(AW)) bus ();

  prog_loader #(
    .INST_MEM_ADDR_SIZE(AW),
    .TIMEOUT_CYCLES    (TMO),
    .SYNC_BYTE         (SYNC)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] byte_q[$];
  wr_t        exp_q[$];
  wr_t        obs_q[$];
  int         done_cnt = 0;
  int         m_done;
  logic       m_err;
  logic [1:0] m_code;
  int         base_w;
  int         base_d;
  vec_t       vecs[7];
  stall_t     stalls[3];

  // Observe the programming port away from the active edge.
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.programming_data_valid) obs_q.push_back('{bus.inst_mem_offset, bus.inst});
      if (bus.programming_done) done_cnt++;
    end
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int waits;
    waits = 0;
    @(negedge clk);
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && waits < 8) begin
      @(negedge clk);
      waits++;
    end
    if (!bus.in_ready) begin
      n_checks++;
      n_errors++;
      $display("[TB] FAIL in_ready wait: got 0, expected 1 within 8 cycles");
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_stream(input int max_gap);
    foreach (byte_q[i]) begin
      idle($urandom_range(0, max_gap));
      send_byte(byte_q[i]);
    end
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Append one frame to byte_q. Words are the two fixed test words or random.
  task automatic append_frame(input logic [15:0] len_field, input int nwords,
                              input bit fixed, input logic [7:0] flip);
    logic [7:0]  x;
    logic [31:0] w;
    byte_q.push_back(SYNC);
    byte_q.push_back(len_field[7:0]);
    byte_q.push_back(len_field[15:8]);
    x = len_field[7:0] ^ len_field[15:8];
    for (int k = 0; k < nwords; k++) begin
      if (fixed) w = (k == 0) ? 32'h0000_0013 : 32'h0010_0093;
      else       w = $urandom;
      for (int b = 0; b < 4; b++) begin
        byte_q.push_back(w[8*b +: 8]);
        x = x ^ w[8*b +: 8];
      end
    end
    if (nwords > 0) byte_q.push_back(x ^ flip);
  endtask

  // Reference model: parse the accepted byte list frame by frame.
  task automatic run_model();
    int          i;
    int          n;
    int          k;
    logic [15:0] len;
    logic [7:0]  x;
    logic [31:0] w;
    exp_q.delete();
    m_done = 0;
    m_err  = 1'b0;
    m_code = 2'b00;
    i = 0;
    n = byte_q.size();
    while (i < n) begin
      if (byte_q[i] != SYNC) begin
        i++;
        continue;
      end
      i++;
      m_err  = 1'b0;
      m_code = 2'b00;
      if (i + 2 > n) break;
      len = {byte_q[i+1], byte_q[i]};
      x   = byte_q[i] ^ byte_q[i+1];
      i  += 2;
      if (len == 0 || int'(len) > MAX_WORDS) begin
        m_err  = 1'b1;
        m_code = 2'b01;
        continue;
      end
      for (k = 0; k < int'(len) && i + 4 <= n; k++) begin
        w = {byte_q[i+3], byte_q[i+2], byte_q[i+1], byte_q[i]};
        x = x ^ byte_q[i] ^ byte_q[i+1] ^ byte_q[i+2] ^ byte_q[i+3];
        exp_q.push_back('{AW'(k), w});
        i += 4;
      end
      if (k < int'(len) || i >= n) break;
      if (byte_q[i] == x) m_done++;
      else begin
        m_err  = 1'b1;
        m_code = 2'b10;
      end
      i++;
    end
  endtask

  task automatic compare_writes(input string tag, input int base);
    chk({tag, " write count vs model"}, obs_q.size() - base, exp_q.size());
    for (int k = 0; k < exp_q.size() && base + k < obs_q.size(); k++) begin
      chk($sformatf("%s wr%0d offset", tag, k), 32'(obs_q[base+k].off), 32'(exp_q[k].off));
      chk($sformatf("%s wr%0d word", tag, k), obs_q[base+k].word, exp_q[k].word);
    end
  endtask

  task automatic applyStimulus(input int max_gap);
    base_w = obs_q.size();
    base_d = done_cnt;
    run_model();
    send_stream(max_gap);
    idle(3);
  endtask

  task automatic checkOutput(input string tag);
    compare_writes(tag, base_w);
    chk({tag, " done count"}, done_cnt - base_d, m_done);
    chk({tag, " error"}, bus.error, m_err);
    chk({tag, " err_code"}, bus.err_code, m_code);
  endtask

  initial begin
    vecs[0] = '{"good2",    16'd2,    2,    1'b1, 8'h00, 2,    1, 1'b0, 2'b00};
    vecs[1] = '{"badcsum",  16'd2,    2,    1'b1, 8'h01, 2,    0, 1'b1, 2'b10};
    vecs[2] = '{"len0",     16'd0,    0,    1'b0, 8'h00, 0,    0, 1'b1, 2'b01};
    vecs[3] = '{"len1025",  16'h0401, 0,    1'b0, 8'h00, 0,    0, 1'b1, 2'b01};
    vecs[4] = '{"len1",     16'd1,    1,    1'b0, 8'h00, 1,    1, 1'b0, 2'b00};
    vecs[5] = '{"len1024",  16'd1024, 1024, 1'b0, 8'h00, 1024, 1, 1'b0, 2'b00};
    vecs[6] = '{"len7bad",  16'd7,    7,    1'b0, 8'h80, 7,    0, 1'b1, 2'b10};
    stalls[0] = '{4, 2, 1, 1'b0, 2'b00};
    stalls[1] = '{5, 2, 1, 1'b0, 2'b00};
    stalls[2] = '{6, 0, 0, 1'b1, 2'b11};

    reset_n      = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;

    // Reset state.
    @(posedge clk);
    #1;
    chk("reset inst", bus.inst, 32'h0);
    chk("reset offset", 32'(bus.inst_mem_offset), 32'h0);
    chk("reset data_valid", bus.programming_data_valid, 1'b0);
    chk("reset done", bus.programming_done, 1'b0);
    chk("reset busy", bus.busy, 1'b0);
    chk("reset error", bus.error, 1'b0);
    chk("reset err_code", bus.err_code, 2'b00);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("in_ready after reset", bus.in_ready, 1'b1);

    // Strobe and done latency on the fixed 2-word frame (CSUM = 0x92).
    send_byte(SYNC); send_byte(8'h02); send_byte(8'h00);
    chk("busy in frame", bus.busy, 1'b1);
    send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    chk("lat w0 strobe", bus.programming_data_valid, 1'b1);
    chk("lat w0 inst", bus.inst, 32'h0000_0013);
    chk("lat w0 offset", 32'(bus.inst_mem_offset), 32'd0);
    idle(1);
    chk("lat w0 strobe one cycle", bus.programming_data_valid, 1'b0);
    send_byte(8'h93); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
    chk("lat w1 strobe", bus.programming_data_valid, 1'b1);
    chk("lat w1 inst", bus.inst, 32'h0010_0093);
    chk("lat w1 offset", 32'(bus.inst_mem_offset), 32'd1);
    send_byte(8'h92);
    chk("lat done pulse", bus.programming_done, 1'b1);
    chk("lat in_ready in DONE", bus.in_ready, 1'b0);
    idle(1);
    chk("lat done one cycle", bus.programming_done, 1'b0);
    chk("lat in_ready after DONE", bus.in_ready, 1'b1);
    chk("lat error", bus.error, 1'b0);

    // Table of frames, back to back.
    for (int v = 0; v < 7; v++) begin
      byte_q.delete();
      append_frame(vecs[v].len_field, vecs[v].nwords, vecs[v].fixed, vecs[v].flip);
      applyStimulus(0);
      chk({vecs[v].name, " writes"}, obs_q.size() - base_w, vecs[v].exp_writes);
      chk({vecs[v].name, " done"}, done_cnt - base_d, vecs[v].exp_done);
      chk({vecs[v].name, " error"}, bus.error, vecs[v].exp_err);
      chk({vecs[v].name, " err_code"}, bus.err_code, vecs[v].exp_code);
      chk({vecs[v].name, " busy"}, bus.busy, 1'b0);
      compare_writes(vecs[v].name, base_w);
    end

    // Sync byte clears a sticky checksum error.
    send_byte(SYNC);
    chk("sync clears error", bus.error, 1'b0);
    chk("sync clears err_code", bus.err_code, 2'b00);
    chk("sync enters frame", bus.busy, 1'b1);
    do_reset();

    // Mid-word stalls against TIMEOUT_CYCLES=5.
    for (int s = 0; s < 3; s++) begin
      base_w = obs_q.size();
      base_d = done_cnt;
      send_byte(SYNC); send_byte(8'h02); send_byte(8'h00);
      send_byte(8'h13); send_byte(8'h00);
      idle(stalls[s].stall);
      send_byte(8'h00); send_byte(8'h00);
      send_byte(8'h93); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
      send_byte(8'h92);
      idle(3);
      chk($sformatf("stall%0d writes", stalls[s].stall), obs_q.size() - base_w, stalls[s].exp_writes);
      chk($sformatf("stall%0d done", stalls[s].stall), done_cnt - base_d, stalls[s].exp_done);
      chk($sformatf("stall%0d error", stalls[s].stall), bus.error, stalls[s].exp_err);
      chk($sformatf("stall%0d err_code", stalls[s].stall), bus.err_code, stalls[s].exp_code);
    end
    do_reset();

    // Random streams with leading garbage and random valid gaps.
    for (int r = 0; r < 6; r++) begin
      byte_q.delete();
      byte_q.push_back(8'h00); byte_q.push_back(8'hFF); byte_q.push_back(8'h5A);
      append_frame(16'($urandom_range(1, 6)), 0, 1'b0, 8'h00);
      byte_q.delete();
      byte_q.push_back(8'h00); byte_q.push_back(8'hFF); byte_q.push_back(8'h5A);
      begin
        automatic int l1 = $urandom_range(1, 6);
        automatic int l2 = $urandom_range(1, 6);
        append_frame(16'(l1), l1, 1'b0, ($urandom_range(0, 3) == 0) ? 8'h01 : 8'h00);
        byte_q.push_back(8'h5A);
        append_frame(16'(l2), l2, 1'b0, ($urandom_range(0, 3) == 0) ? 8'h40 : 8'h00);
      end
      applyStimulus(3);
      checkOutput($sformatf("rand%0d", r));
    end

    // Reset in the middle of a frame, then a fresh full frame.
    do_reset();
    send_byte(SYNC); send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h93);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midreset inst", bus.inst, 32'h0);
    chk("midreset offset", 32'(bus.inst_mem_offset), 32'h0);
    chk("midreset data_valid", bus.programming_data_valid, 1'b0);
    chk("midreset done", bus.programming_done, 1'b0);
    chk("midreset busy", bus.busy, 1'b0);
    chk("midreset error", bus.error, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    byte_q.delete();
    append_frame(16'd2, 2, 1'b1, 8'h00);
    applyStimulus(1);
    checkOutput("after reset");
    chk("after reset done", done_cnt - base_d, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
